// File: rtl/dog_extrema.sv
// dog_extrema: scans the interior of a DIMENSION x DIMENSION mid DoG layer and
// reports every pixel that is a strict 3x3x3 extremum (against below/mid/above
// layers) with |value| > THRESHOLD as an (x, y) keypoint.
//
// Ports:
//   clk, rst_in            clock, synchronous active-low reset
//   start                  pulse in IDLE to begin a scan at centre (1,1)
//   below/mid/above_pix    signed samples returned by the three BRAMs
//   address                shared BRAM read address (registered)
//   key_valid/ready/x/y    keypoint handshake to the descriptor stage
//   busy, done, state_num  status: scan active, end-of-scan pulse, FSM state
module dog_extrema #(
  parameter int DIMENSION    = 64,
  parameter int BIT_DEPTH    = 9,
  parameter int THRESHOLD    = 3,
  parameter int BRAM_LATENCY = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_in,
  input  logic                                   start,
  input  logic signed [BIT_DEPTH-1:0]            below_pix,
  input  logic signed [BIT_DEPTH-1:0]            mid_pix,
  input  logic signed [BIT_DEPTH-1:0]            above_pix,
  output logic [$clog2(DIMENSION*DIMENSION)-1:0] address,
  output logic                                   key_valid,
  input  logic                                   key_ready,
  output logic [$clog2(DIMENSION)-1:0]           key_x,
  output logic [$clog2(DIMENSION)-1:0]           key_y,
  output logic                                   busy,
  output logic                                   done,
  output logic [1:0]                             state_num
);

  localparam int AW        = $clog2(DIMENSION*DIMENSION);
  localparam int XW        = $clog2(DIMENSION);
  localparam int FETCH_LEN = 9 + BRAM_LATENCY;
  localparam int CW        = $clog2(FETCH_LEN + 1);

  localparam logic [CW-1:0] CNT_LAST   = CW'(FETCH_LEN - 1);
  localparam logic [CW-1:0] CNT_ISSUED = CW'(8);
  localparam logic [XW-1:0] C_FIRST    = XW'(1);
  localparam logic [XW-1:0] C_LAST     = XW'(DIMENSION - 2);

  localparam logic signed [BIT_DEPTH-1:0] TH_POS = BIT_DEPTH'(THRESHOLD);
  localparam logic signed [BIT_DEPTH-1:0] TH_NEG = -TH_POS;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_COMPARE = 2'd2,
    S_EMIT    = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XW-1:0]   cx_q, cx_d, cy_q, cy_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            done_q, done_d;

  // Neighbourhood samples, slot k = (dy+1)*3 + (dx+1); slot 4 of mid is the centre.
  logic signed [BIT_DEPTH-1:0] bel_q [9];
  logic signed [BIT_DEPTH-1:0] mid_q [9];
  logic signed [BIT_DEPTH-1:0] abv_q [9];

  // Address of neighbour k around centre (x, y).
  function automatic logic [AW-1:0] nb_addr(input logic [XW-1:0] x,
                                            input logic [XW-1:0] y,
                                            input int k);
    int a;
    a = (int'(y) + k / 3 - 1) * DIMENSION + int'(x) + k % 3 - 1;
    return AW'(a);
  endfunction

  // Centre advance in raster order over the interior.
  logic [XW-1:0] nx, ny;
  logic          last_ctr;
  assign nx       = (cx_q == C_LAST) ? C_FIRST : cx_q + XW'(1);
  assign ny       = (cx_q == C_LAST) ? cy_q + XW'(1) : cy_q;
  assign last_ctr = (cx_q == C_LAST) && (cy_q == C_LAST);

  // Extremum test: any tie clears both flags.
  logic signed [BIT_DEPTH-1:0] c;
  logic gt_all, lt_all, is_key;
  assign c = mid_q[4];

  always_comb begin
    gt_all = 1'b1;
    lt_all = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (!(c > bel_q[k])) gt_all = 1'b0;
      if (!(c < bel_q[k])) lt_all = 1'b0;
      if (!(c > abv_q[k])) gt_all = 1'b0;
      if (!(c < abv_q[k])) lt_all = 1'b0;
      if (k != 4) begin
        if (!(c > mid_q[k])) gt_all = 1'b0;
        if (!(c < mid_q[k])) lt_all = 1'b0;
      end
    end
    is_key = (gt_all && (c > TH_POS)) || (lt_all && (c < TH_NEG));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cx_d    = C_FIRST;
          cy_d    = C_FIRST;
          cnt_d   = '0;
          addr_d  = nb_addr(C_FIRST, C_FIRST, 0);
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        cnt_d = cnt_q + CW'(1);
        // Address k+1 is loaded while address k is on the bus; the last
        // address then holds while the pipeline drains.
        if (cnt_q < CNT_ISSUED) addr_d = nb_addr(cx_q, cy_q, int'(cnt_q) + 1);
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_COMPARE;
        end
      end
      S_COMPARE, S_EMIT: begin
        if ((state_q == S_COMPARE && is_key)) begin
          state_d = S_EMIT;
        end else if (state_q == S_COMPARE || key_ready) begin
          if (last_ctr) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            cx_d    = nx;
            cy_d    = ny;
            cnt_d   = '0;
            addr_d  = nb_addr(nx, ny, 0);
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
    end
  end

  // Data for the address issued at count k arrives at count k+BRAM_LATENCY.
  always_ff @(posedge clk) begin
    if (!rst_in) begin
      for (int k = 0; k < 9; k++) begin
        bel_q[k] <= '0;
        mid_q[k] <= '0;
        abv_q[k] <= '0;
      end
    end else if (state_q == S_FETCH) begin
      for (int k = 0; k < 9; k++) begin
        if (cnt_q == CW'(k + BRAM_LATENCY)) begin
          bel_q[k] <= below_pix;
          mid_q[k] <= mid_pix;
          abv_q[k] <= above_pix;
        end
      end
    end
  end

  assign address   = addr_q;
  assign key_valid = (state_q == S_EMIT);
  assign key_x     = cx_q;
  assign key_y     = cy_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign state_num = state_q;

endmodule

// File: tb/tb_dog_extrema.sv
module tb_dog_extrema;
  localparam int D  = 4;
  localparam int BW = 9;

  logic                 clk = 1'b0;
  logic                 rst_in, start, key_ready;
  logic signed [BW-1:0] below_pix, mid_pix, above_pix;
  logic [3:0]           address;
  logic                 key_valid, busy, done;
  logic [1:0]           key_x, key_y, state_num;

  dog_extrema #(.DIMENSION(D), .BIT_DEPTH(BW), .THRESHOLD(3), .BRAM_LATENCY(2)) dut (
    .clk(clk), .rst_in(rst_in), .start(start),
    .below_pix(below_pix), .mid_pix(mid_pix), .above_pix(above_pix),
    .address(address), .key_valid(key_valid), .key_ready(key_ready),
    .key_x(key_x), .key_y(key_y), .busy(busy), .done(done), .state_num(state_num)
  );

  always #5 clk = ~clk;

  // Three BRAMs, two-cycle read latency.
  logic signed [BW-1:0] mb [16], mm [16], ma [16];
  logic signed [BW-1:0] b1, m1, a1;
  always @(posedge clk) begin
    b1 <= mb[address]; m1 <= mm[address]; a1 <= ma[address];
    below_pix <= b1;   mid_pix <= m1;     above_pix <= a1;
  end

  int n_chk = 0, n_pass = 0;
  int kx[$], ky[$], alog[$];
  int done_cnt;
  bit log_en;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  always @(negedge clk) begin
    #1;
    if (key_valid && key_ready) begin kx.push_back(key_x); ky.push_back(key_y); end
    if (done) done_cnt++;
    if (log_en && state_num == 2'd1 && key_x == 2'd2 && key_y == 2'd2) alog.push_back(address);
  end

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) begin mb[i] = '0; mm[i] = '0; ma[i] = '0; end
  endtask

  task automatic clear_log();
    kx.delete(); ky.delete(); alog.delete(); done_cnt = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Runs one scan; cyc = cycles from busy rising to done.
  task automatic do_scan(input string tag, output int cyc);
    clear_log();
    pulse_start();
    chk({tag, "_busy_start"}, busy, 1);
    cyc = 0;
    while (!done && cyc < 2000) begin @(negedge clk); cyc++; end
    chk({tag, "_done_seen"}, done, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_key(input string tag, input int x, input int y);
    chk({tag, "_nkeys"}, kx.size(), 1);
    chk({tag, "_kx"}, (kx.size() > 0) ? kx[0] : -1, x);
    chk({tag, "_ky"}, (ky.size() > 0) ? ky[0] : -1, y);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_state"}, state_num, 0);
    chk({tag, "_addr"}, address, 0);
    chk({tag, "_kv"}, key_valid, 0);
    chk({tag, "_kx"}, key_x, 0);
    chk({tag, "_ky"}, key_y, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    int cyc, w;
    int exp_a [9] = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
    rst_in = 1'b0; start = 1'b0; key_ready = 1'b1; log_en = 1'b0;
    clear_mem();
    clear_log();
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_in = 1'b1;

    // Flat layers: no key, 4 centres x 12 cycles.
    do_scan("flat", cyc);
    chk("flat_cycles", cyc, 48);
    chk("flat_nkeys", kx.size(), 0);
    chk("flat_done_once", done_cnt, 1);
    chk("flat_busy_end", busy, 0);

    // Single peak at (2,2), plus the address trace for that centre.
    mm[10] = 50; log_en = 1'b1;
    do_scan("peak", cyc);
    log_en = 1'b0;
    chk_key("peak", 2, 2);
    chk("peak_cycles", cyc, 49);
    chk("peak_alog_len", alog.size(), 11);
    for (int i = 0; i < 9; i++)
      chk($sformatf("peak_addr%0d", i), (alog.size() > i) ? alog[i] : -1, exp_a[i]);

    // Tie with the above layer disqualifies.
    ma[5] = 50;
    do_scan("tie", cyc);
    chk("tie_nkeys", kx.size(), 0);

    // Minimum at (1,2).
    clear_mem(); mm[9] = -40;
    do_scan("min", cyc);
    chk_key("min", 1, 2);

    // Threshold boundaries.
    clear_mem(); mm[10] = 3;
    do_scan("th3", cyc);
    chk("th3_nkeys", kx.size(), 0);
    mm[10] = 4;
    do_scan("th4", cyc);
    chk_key("th4", 2, 2);
    mm[10] = -3;
    do_scan("thm3", cyc);
    chk("thm3_nkeys", kx.size(), 0);
    mm[10] = -4;
    do_scan("thm4", cyc);
    chk_key("thm4", 2, 2);

    // Backpressure: peak at (1,2), ready low for 5 cycles.
    clear_mem(); mm[9] = 50;
    clear_log();
    key_ready = 1'b0;
    pulse_start();
    w = 0;
    while (!key_valid && w < 200) begin @(negedge clk); w++; end
    chk("stall_kv_seen", key_valid, 1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall_kv%0d", i), key_valid, 1);
      chk($sformatf("stall_kx%0d", i), key_x, 1);
      chk($sformatf("stall_ky%0d", i), key_y, 2);
      @(negedge clk);
    end
    chk("stall_no_xfer", kx.size(), 0);
    key_ready = 1'b1;
    @(negedge clk);
    chk("stall_xfer", kx.size(), 1);
    chk("stall_kv_drop", key_valid, 0);
    chk("stall_resume_state", state_num, 1);
    chk("stall_resume_x", key_x, 2);
    chk("stall_resume_y", key_y, 2);
    w = 0;
    while (!done && w < 200) begin @(negedge clk); w++; end
    chk("stall_done", done, 1);
    repeat (2) @(negedge clk);
    chk("stall_total_keys", kx.size(), 1);

    // Reset during FETCH, then a clean rescan.
    clear_mem(); mm[10] = 50;
    pulse_start();
    repeat (3) @(negedge clk);
    chk("rstf_in_fetch", state_num, 1);
    rst_in = 1'b0;
    @(negedge clk);
    chk_zero("rstf");
    rst_in = 1'b1;
    do_scan("rstf_rescan", cyc);
    chk_key("rstf_rescan", 2, 2);
    chk("rstf_rescan_cycles", cyc, 49);

    // Reset while a key is being presented.
    key_ready = 1'b0;
    pulse_start();
    w = 0;
    while (!key_valid && w < 200) begin @(negedge clk); w++; end
    chk("rste_kv_seen", key_valid, 1);
    rst_in = 1'b0;
    @(negedge clk);
    chk_zero("rste");
    rst_in = 1'b1;
    key_ready = 1'b1;
    do_scan("rste_rescan", cyc);
    chk_key("rste_rescan", 2, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
